// File: rtl/arb_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
package arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   // Index width for an N-way arbiter, never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic [31:0] onehot2bin(input logic [31:0] oh);
      logic [31:0] bin;
      bin = 32'd0;
      for (int i = 0; i < 32; i++) begin
         bin = oh[i] ? 32'(i) : bin;
      end
      return bin;
   endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational rotating-priority pick: the requester just above ptr wins, ptr itself ranks lowest.
module arb_rr_pick
   import arb_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]        req,
   input  logic [idx_w(N)-1:0] ptr,
   output logic [N-1:0]        pick,
   output logic [idx_w(N)-1:0] pick_idx,
   output logic                pick_valid
);

   localparam int IDX_W = idx_w(N);
   localparam logic [N-1:0] ONE_N = {{(N-1){1'b0}}, 1'b1};

   logic [IDX_W:0] shamt_s;
   logic [N-1:0]   rot_s;
   logic [N-1:0]   sel_rot_s;

   // Rotate req so position 0 is ptr+1, take the lowest set bit, rotate the winner back.
   always_comb begin
      shamt_s   = {1'b0, ptr} + {{IDX_W{1'b0}}, 1'b1};
      rot_s     = N'({req, req} >> shamt_s);
      sel_rot_s = {N{1'b0}};
      for (int j = N - 1; j >= 0; j--) begin
         sel_rot_s = rot_s[j] ? (ONE_N << j) : sel_rot_s;
      end
      pick       = N'(({sel_rot_s, sel_rot_s} << shamt_s) >> N);
      pick_idx   = IDX_W'(onehot2bin(32'(pick)));
      pick_valid = |req;
   end

endmodule

// File: rtl/arbiter_weighted_rr.sv
// Weighted round-robin arbiter: registered one-hot grant, per-requester beat credit.
// Optional ARB_WRR_PKT_LOCK_EN holds the grant until the last beat of a packet.
module arbiter_weighted_rr
   import arb_pkg::*;
#(
   parameter int N        = 4,
   parameter int WEIGHT_W = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N-1:0]          req,
   input  logic [N*WEIGHT_W-1:0] weight,
   input  logic                  ready,
   input  logic                  pkt_last,
   output logic [N-1:0]          grant,
   output logic                  grant_valid,
   output logic [idx_w(N)-1:0]   grant_idx
);

   localparam int IDX_W = idx_w(N);
   localparam logic [WEIGHT_W-1:0] CREDIT_ONE = {{(WEIGHT_W-1){1'b0}}, 1'b1};
   localparam logic [IDX_W-1:0]    PTR_RST    = IDX_W'(N - 1);

   arb_state_e          state_r, state_nxt_s;
   logic [N-1:0]        grant_r, grant_nxt_s;
   logic                valid_r;
   logic [IDX_W-1:0]    idx_r, idx_nxt_s;
   logic [WEIGHT_W-1:0] credit_r, credit_nxt_s;
   logic [IDX_W-1:0]    ptr_r, ptr_nxt_s;

   logic [IDX_W-1:0]    pick_ptr_s;
   logic [N-1:0]        pick_s;
   logic [IDX_W-1:0]    pick_idx_s;
   logic                pick_valid_s;
   logic [WEIGHT_W-1:0] pick_weight_s;
   logic [WEIGHT_W-1:0] load_credit_s;
   logic                xfer_s;
   logic                cred_one_s;
   logic                rel_s;

`ifndef ARB_WRR_PKT_LOCK_EN
   logic                pkt_last_unused_s;
   assign pkt_last_unused_s = pkt_last;
`endif

   // Release condition and the pointer the picker ranks from this cycle.
   always_comb begin
      xfer_s     = valid_r & ready;
      cred_one_s = (credit_r == CREDIT_ONE);
`ifdef ARB_WRR_PKT_LOCK_EN
      rel_s      = (state_r == GRANT) & xfer_s & pkt_last & cred_one_s;
`else
      rel_s      = (state_r == GRANT) & ((xfer_s & cred_one_s) | ~req[idx_r]);
`endif
      pick_ptr_s = rel_s ? idx_r : ptr_r;
   end

   arb_rr_pick #(
      .N (N)
   ) u_pick (
      .req        (req),
      .ptr        (pick_ptr_s),
      .pick       (pick_s),
      .pick_idx   (pick_idx_s),
      .pick_valid (pick_valid_s)
   );

   // Credit for a fresh grant; a zero weight still earns one beat.
   always_comb begin
      pick_weight_s = weight[pick_idx_s*WEIGHT_W +: WEIGHT_W];
      load_credit_s = (pick_weight_s == {WEIGHT_W{1'b0}}) ? CREDIT_ONE : pick_weight_s;
   end

   // Next-state logic: grant/credit/ptr updates for both FSM states.
   always_comb begin
      state_nxt_s  = state_r;
      grant_nxt_s  = grant_r;
      idx_nxt_s    = idx_r;
      credit_nxt_s = credit_r;
      ptr_nxt_s    = ptr_r;
      case (state_r)
         IDLE: begin
            if (pick_valid_s) begin
               state_nxt_s  = GRANT;
               grant_nxt_s  = pick_s;
               idx_nxt_s    = pick_idx_s;
               credit_nxt_s = load_credit_s;
            end else begin
               state_nxt_s  = IDLE;
            end
         end
         GRANT: begin
            if (rel_s) begin
               ptr_nxt_s = idx_r;
               if (pick_valid_s) begin
                  state_nxt_s  = GRANT;
                  grant_nxt_s  = pick_s;
                  idx_nxt_s    = pick_idx_s;
                  credit_nxt_s = load_credit_s;
               end else begin
                  state_nxt_s  = IDLE;
                  grant_nxt_s  = {N{1'b0}};
                  idx_nxt_s    = {IDX_W{1'b0}};
                  credit_nxt_s = {WEIGHT_W{1'b0}};
               end
            end else if (xfer_s && (credit_r > CREDIT_ONE)) begin
               credit_nxt_s = credit_r - CREDIT_ONE;
            end else begin
               // Stall, or locked at credit one waiting for the packet end.
               credit_nxt_s = credit_r;
            end
         end
         default: begin
            state_nxt_s  = IDLE;
            grant_nxt_s  = {N{1'b0}};
            idx_nxt_s    = {IDX_W{1'b0}};
            credit_nxt_s = {WEIGHT_W{1'b0}};
            ptr_nxt_s    = PTR_RST;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r  <= IDLE;
         grant_r  <= {N{1'b0}};
         valid_r  <= 1'b0;
         idx_r    <= {IDX_W{1'b0}};
         credit_r <= {WEIGHT_W{1'b0}};
         ptr_r    <= PTR_RST;
      end else begin
         state_r  <= state_nxt_s;
         grant_r  <= grant_nxt_s;
         valid_r  <= |grant_nxt_s;
         idx_r    <= idx_nxt_s;
         credit_r <= credit_nxt_s;
         ptr_r    <= ptr_nxt_s;
      end
   end

   assign grant       = grant_r;
   assign grant_valid = valid_r;
   assign grant_idx   = idx_r;

endmodule

// File: tb/tb_arbiter_weighted_rr.sv
// Self-checking bench for arbiter_weighted_rr: per-cycle vector table with a scoreboard queue.
module tb_arbiter_weighted_rr;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req;
   logic [15:0] weight;
   logic        ready;
   logic        pkt_last;
   logic [3:0]  grant;
   logic        grant_valid;
   logic [1:0]  grant_idx;

   always #5 clk = ~clk;

   arbiter_weighted_rr #(
      .N        (4),
      .WEIGHT_W (4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .weight      (weight),
      .ready       (ready),
      .pkt_last    (pkt_last),
      .grant       (grant),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx)
   );

   typedef struct {
      logic        rst_n;
      logic [3:0]  req;
      logic [15:0] weight;
      logic        ready;
      logic        pkt_last;
      logic [3:0]  exp_grant;
      string       name;
   } vec_t;

   typedef struct {
      logic [3:0] grant;
      logic       valid;
      logic [1:0] idx;
      string      name;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   function automatic void add(input logic r, input logic [3:0] rq, input logic [15:0] w,
                               input logic rdy, input logic last, input logic [3:0] eg,
                               input string nm);
      vec_t v;
      v.rst_n = r; v.req = rq; v.weight = w; v.ready = rdy; v.pkt_last = last;
      v.exp_grant = eg; v.name = nm;
      vecs.push_back(v);
   endfunction

   function automatic logic [1:0] idx_of(input logic [3:0] g);
      case (g)
         4'b0010: return 2'd1;
         4'b0100: return 2'd2;
         4'b1000: return 2'd3;
         default: return 2'd0;
      endcase
   endfunction

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      // 1: reset held with all requesting
      for (int i = 0; i < 3; i++) add(1'b0, 4'b1111, 16'h1111, 1'b1, 1'b0, 4'b0000, "t1_reset");
      // 2: equal weights, plain round robin with no bubbles
      add(1'b1, 4'b1111, 16'h1111, 1'b1, 1'b0, 4'b0001, "t2_rr");
      add(1'b1, 4'b1111, 16'h1111, 1'b1, 1'b0, 4'b0010, "t2_rr");
      add(1'b1, 4'b1111, 16'h1111, 1'b1, 1'b0, 4'b0100, "t2_rr");
      add(1'b1, 4'b1111, 16'h1111, 1'b1, 1'b0, 4'b1000, "t2_rr");
      add(1'b1, 4'b1111, 16'h1111, 1'b1, 1'b0, 4'b0001, "t2_rr");
      add(1'b1, 4'b1111, 16'h1111, 1'b1, 1'b0, 4'b0010, "t2_rr");
      // 3: weights w0=3 w1=1 w2=2 w3=1
      add(1'b0, 4'b1111, 16'h1213, 1'b1, 1'b0, 4'b0000, "t3_rst");
      add(1'b1, 4'b1111, 16'h1213, 1'b1, 1'b0, 4'b0001, "t3_wrr");
      add(1'b1, 4'b1111, 16'h1213, 1'b1, 1'b0, 4'b0001, "t3_wrr");
      add(1'b1, 4'b1111, 16'h1213, 1'b1, 1'b0, 4'b0001, "t3_wrr");
      add(1'b1, 4'b1111, 16'h1213, 1'b1, 1'b0, 4'b0010, "t3_wrr");
      add(1'b1, 4'b1111, 16'h1213, 1'b1, 1'b0, 4'b0100, "t3_wrr");
      add(1'b1, 4'b1111, 16'h1213, 1'b1, 1'b0, 4'b0100, "t3_wrr");
      add(1'b1, 4'b1111, 16'h1213, 1'b1, 1'b0, 4'b1000, "t3_wrr");
      add(1'b1, 4'b1111, 16'h1213, 1'b1, 1'b0, 4'b0001, "t3_wrr");
      // 4: requester 2 (w2=3) stalled five cycles, then counts its three beats
      add(1'b0, 4'b1100, 16'h1300, 1'b0, 1'b0, 4'b0000, "t4_rst");
      for (int i = 0; i < 6; i++) add(1'b1, 4'b1100, 16'h1300, 1'b0, 1'b0, 4'b0100, "t4_stall");
      add(1'b1, 4'b1100, 16'h1300, 1'b1, 1'b0, 4'b0100, "t4_resume");
      add(1'b1, 4'b1100, 16'h1300, 1'b1, 1'b0, 4'b0100, "t4_resume");
      add(1'b1, 4'b1100, 16'h1300, 1'b1, 1'b0, 4'b1000, "t4_resume");
      add(1'b1, 4'b1100, 16'h1300, 1'b1, 1'b0, 4'b0100, "t4_resume");
      // 5: zero weight behaves as one
      add(1'b0, 4'b0010, 16'h1101, 1'b1, 1'b0, 4'b0000, "t5_rst");
      add(1'b1, 4'b0010, 16'h1101, 1'b1, 1'b0, 4'b0010, "t5_w0");
      add(1'b1, 4'b0110, 16'h1101, 1'b1, 1'b0, 4'b0100, "t5_w0");
      add(1'b1, 4'b0110, 16'h1101, 1'b1, 1'b0, 4'b0010, "t5_w0");
      // 6: granted requester drops its request while stalled
      add(1'b0, 4'b0010, 16'h1111, 1'b0, 1'b0, 4'b0000, "t6_rst");
      add(1'b1, 4'b0010, 16'h1111, 1'b0, 1'b0, 4'b0010, "t6_drop");
`ifdef ARB_WRR_PKT_LOCK_EN
      add(1'b1, 4'b1001, 16'h1111, 1'b0, 1'b0, 4'b0010, "t6_lock_hold");
      add(1'b1, 4'b1001, 16'h1111, 1'b1, 1'b1, 4'b1000, "t6_lock_rel");
      // 7: packet lock keeps requester 0 for four beats despite w0=1
      add(1'b0, 4'b0011, 16'h1111, 1'b1, 1'b0, 4'b0000, "t7_rst");
      add(1'b1, 4'b0011, 16'h1111, 1'b1, 1'b0, 4'b0001, "t7_lock");
      add(1'b1, 4'b0011, 16'h1111, 1'b1, 1'b0, 4'b0001, "t7_lock");
      add(1'b1, 4'b0011, 16'h1111, 1'b1, 1'b0, 4'b0001, "t7_lock");
      add(1'b1, 4'b0011, 16'h1111, 1'b1, 1'b0, 4'b0001, "t7_lock");
      add(1'b1, 4'b0011, 16'h1111, 1'b1, 1'b1, 4'b0010, "t7_lock");
`else
      add(1'b1, 4'b1001, 16'h1111, 1'b0, 1'b0, 4'b1000, "t6_drop");
      add(1'b1, 4'b0001, 16'h1111, 1'b0, 1'b0, 4'b0001, "t6_wrap");
      add(1'b1, 4'b0000, 16'h1111, 1'b0, 1'b0, 4'b0000, "t6_none");
      // 7: pkt_last has no effect without packet lock
      add(1'b0, 4'b0011, 16'h1112, 1'b1, 1'b0, 4'b0000, "t7_rst");
      add(1'b1, 4'b0011, 16'h1112, 1'b1, 1'b0, 4'b0001, "t7_nolock");
      add(1'b1, 4'b0011, 16'h1112, 1'b1, 1'b1, 4'b0001, "t7_nolock");
      add(1'b1, 4'b0011, 16'h1112, 1'b1, 1'b0, 4'b0010, "t7_nolock");
`endif
      // 8: reset in the middle of a burst, then fresh priority order
      add(1'b0, 4'b1111, 16'h1113, 1'b1, 1'b0, 4'b0000, "t8_rst");
      add(1'b1, 4'b1111, 16'h1113, 1'b1, 1'b0, 4'b0001, "t8_burst");
      add(1'b1, 4'b1111, 16'h1113, 1'b1, 1'b0, 4'b0001, "t8_burst");
      add(1'b0, 4'b1111, 16'h1113, 1'b1, 1'b0, 4'b0000, "t8_midrst");
      add(1'b1, 4'b1110, 16'h1113, 1'b1, 1'b0, 4'b0010, "t8_after");

      rst_n = 1'b0; req = 4'b0000; weight = 16'h1111; ready = 1'b0; pkt_last = 1'b0;
      @(posedge clk); #1;

      foreach (vecs[i]) begin
         rst_n    = vecs[i].rst_n;
         req      = vecs[i].req;
         weight   = vecs[i].weight;
         ready    = vecs[i].ready;
         pkt_last = vecs[i].pkt_last;
         e.grant = vecs[i].exp_grant;
         e.valid = |vecs[i].exp_grant;
         e.idx   = idx_of(vecs[i].exp_grant);
         e.name  = $sformatf("%s[%0d]", vecs[i].name, i);
         sb.push_back(e);
         @(posedge clk); #1;
         e = sb.pop_front();
         chk({e.name, "/grant"}, grant, e.grant);
         chk({e.name, "/grant_valid"}, {3'b000, grant_valid}, {3'b000, e.valid});
         chk({e.name, "/grant_idx"}, {2'b00, grant_idx}, {2'b00, e.idx});
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
